lsu_ctrl: RTL and testbench

//  Load/store unit: initiator side of the data-memory request interface.

---
 rtl/lsu_ctrl_if.sv | 20 ++
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// Read data is registered by the memory and valid the cycle after mem_req.
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output mem_req, mem_we, mem_size, mem_a, mem_wd,
        input  mem_rd
    );

    modport slave (
        input  mem_req, mem_we, mem_size, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one core access, issues it on the data-memory bus and returns extended load data.
// Define LSU_FAULT_EN to enable misalignment / bad-size / out-of-region fault detection.
module lsu_ctrl #(
    parameter logic [31:0] STATIC_BASE = 32'h10008000,
    parameter logic [31:0] STATIC_LAST = 32'h100081FF,
    parameter logic [31:0] HEAP_BASE   = 32'h10008200,
    parameter logic [31:0] HEAP_LAST   = 32'h100083FF,
    parameter logic [31:0] STACK_BASE  = 32'hBFFFFDF0,
    parameter logic [31:0] STACK_LAST  = 32'hBFFFFFF0
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_fault_o,
    output logic [31:0] lsu_fault_addr_o,
    output logic [1:0]  dbg_state_o,
    output logic        dbg_in_region_o,
    lsu_ctrl_if.master  mem
);

    // Core handshake: lsu_req_i is held until the one-cycle lsu_done_o pulse; the
    // request visible alongside lsu_done_o is never re-accepted.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_in_region;
    logic        w_fault;
    logic [31:0] w_ext;

    assign w_accept = lsu_req_i & ~r_done;

    assign w_in_region = ((lsu_addr_i >= STATIC_BASE) && (lsu_addr_i <= STATIC_LAST)) ||
                         ((lsu_addr_i >= HEAP_BASE)   && (lsu_addr_i <= HEAP_LAST))   ||
                         ((lsu_addr_i >= STACK_BASE)  && (lsu_addr_i <= STACK_LAST));

`ifdef LSU_FAULT_EN
    logic        r_fault;
    logic [31:0] r_fault_addr;

    always_comb begin
        w_fault = ~w_in_region;
        case (lsu_size_i)
            3'd1, 3'd5:       if (lsu_addr_i[0])          w_fault = 1'b1;
            3'd2:             if (lsu_addr_i[1:0] != 2'b00) w_fault = 1'b1;
            3'd3, 3'd6, 3'd7: w_fault = 1'b1;
            default:          ;
        endcase
    end

    assign lsu_fault_o      = r_fault;
    assign lsu_fault_addr_o = r_fault_addr;
`else
    assign w_fault          = 1'b0;
    assign lsu_fault_o      = 1'b0;
    assign lsu_fault_addr_o = 32'h0;
`endif

    // Extension follows the latched size, not the live core input.
    always_comb begin
        w_ext = mem.mem_rd;
        case (r_size)
            3'd0:    w_ext = {{24{mem.mem_rd[7]}},  mem.mem_rd[7:0]};
            3'd4:    w_ext = {24'h0,                mem.mem_rd[7:0]};
            3'd1:    w_ext = {{16{mem.mem_rd[15]}}, mem.mem_rd[15:0]};
            3'd5:    w_ext = {16'h0,                mem.mem_rd[15:0]};
            default: w_ext = mem.mem_rd;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_rdata   <= 32'h0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_we      <= 1'b0;
            r_size    <= 3'd0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
`ifdef LSU_FAULT_EN
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LSU_FAULT_EN
            r_fault <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            // Faulted access completes from IDLE without touching memory.
                            r_done <= 1'b1;
`ifdef LSU_FAULT_EN
                            r_fault      <= 1'b1;
                            r_fault_addr <= lsu_addr_i;
`endif
                        end else begin
                            r_we      <= lsu_we_i;
                            r_size    <= lsu_size_i;
                            r_addr    <= lsu_addr_i;
                            r_wdata   <= lsu_wdata_i;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= lsu_we_i;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (!r_we) begin
                        r_rdata <= w_ext;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu_stall_o     = (r_state != S_IDLE) | w_accept;
    assign lsu_done_o      = r_done;
    assign lsu_rdata_o     = r_rdata;
    assign dbg_state_o     = r_state;
    assign dbg_in_region_o = w_in_region;

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_we   = r_mem_we;
    assign mem.mem_size = r_size;
    assign mem.mem_a    = r_addr;
    assign mem.mem_wd   = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: latency, extension, stores, faults, back-to-back requests and mid-op reset.
// Build with or without LSU_FAULT_EN; the fault steps follow the same macro.
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_stall_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_fault_o;
    logic [31:0] lsu_fault_addr_o;
    logic [1:0]  dbg_state_o;
    logic        dbg_in_region_o;

    int n_cmp = 0;
    int n_err = 0;

    lsu_ctrl_if mif ();

    lsu_ctrl dut (
        .clk_i            (clk_i),
        .reset            (reset),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_stall_o      (lsu_stall_o),
        .lsu_done_o       (lsu_done_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_fault_o      (lsu_fault_o),
        .lsu_fault_addr_o (lsu_fault_addr_o),
        .dbg_state_o      (dbg_state_o),
        .dbg_in_region_o  (dbg_in_region_o),
        .mem              (mif.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full legal access: accept in cycle 0, mem_req in cycle 1, done in cycle 3.
    task automatic run_op(input string tag, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input logic [31:0] exp_rdata);
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_size_i  = size;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        #1;
        check({tag, ".c0_stall"}, 32'(lsu_stall_o), 32'd1);
        tick();
        check({tag, ".c1_req"},   32'(mif.mem_req), 32'd1);
        check({tag, ".c1_we"},    32'(mif.mem_we), 32'(we));
        check({tag, ".c1_addr"},  mif.mem_a, addr);
        check({tag, ".c1_size"},  32'(mif.mem_size), 32'(size));
        check({tag, ".c1_wd"},    mif.mem_wd, wdata);
        check({tag, ".c1_stall"}, 32'(lsu_stall_o), 32'd1);
        check({tag, ".c1_done"},  32'(lsu_done_o), 32'd0);
        mif.mem_rd = rd;
        tick();
        check({tag, ".c2_req"},   32'(mif.mem_req), 32'd0);
        check({tag, ".c2_state"}, 32'(dbg_state_o), 32'd2);
        check({tag, ".c2_addr"},  mif.mem_a, addr);
        check({tag, ".c2_stall"}, 32'(lsu_stall_o), 32'd1);
        check({tag, ".c2_done"},  32'(lsu_done_o), 32'd0);
        tick();
        check({tag, ".c3_done"},  32'(lsu_done_o), 32'd1);
        check({tag, ".c3_fault"}, 32'(lsu_fault_o), 32'd0);
        check({tag, ".c3_rdata"}, lsu_rdata_o, exp_rdata);
        check({tag, ".c3_stall"}, 32'(lsu_stall_o), 32'd0);
        lsu_req_i  = 1'b0;
        mif.mem_rd = $urandom;
        tick();
        check({tag, ".c4_done"},  32'(lsu_done_o), 32'd0);
        check({tag, ".c4_req"},   32'(mif.mem_req), 32'd0);
        check({tag, ".c4_rdata"}, lsu_rdata_o, exp_rdata);
    endtask

`ifdef LSU_FAULT_EN
    task automatic fault_op(input string tag, input logic we, input logic [2:0] size,
                            input logic [31:0] addr);
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_size_i  = size;
        lsu_addr_i  = addr;
        lsu_wdata_i = 32'h00A5A5A5;
        tick();
        check({tag, ".c1_done"},  32'(lsu_done_o), 32'd1);
        check({tag, ".c1_fault"}, 32'(lsu_fault_o), 32'd1);
        check({tag, ".c1_faddr"}, lsu_fault_addr_o, addr);
        check({tag, ".c1_req"},   32'(mif.mem_req), 32'd0);
        check({tag, ".c1_stall"}, 32'(lsu_stall_o), 32'd0);
        lsu_req_i = 1'b0;
        tick();
        check({tag, ".c2_done"},  32'(lsu_done_o), 32'd0);
        check({tag, ".c2_fault"}, 32'(lsu_fault_o), 32'd0);
        check({tag, ".c2_req"},   32'(mif.mem_req), 32'd0);
    endtask
`endif

    initial begin
        reset       = 1'b1;
        lsu_req_i   = 1'b0;
        lsu_we_i    = 1'b0;
        lsu_size_i  = 3'd0;
        lsu_addr_i  = 32'h0;
        lsu_wdata_i = 32'h0;
        mif.mem_rd  = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        check("rst.rdata", lsu_rdata_o, 32'h0);
        check("rst.faddr", lsu_fault_addr_o, 32'h0);
        check("rst.done",  32'(lsu_done_o), 32'd0);
        check("rst.fault", 32'(lsu_fault_o), 32'd0);
        check("rst.req",   32'(mif.mem_req), 32'd0);
        check("rst.we",    32'(mif.mem_we), 32'd0);
        check("rst.addr",  mif.mem_a, 32'h0);
        check("rst.wd",    mif.mem_wd, 32'h0);
        check("rst.stall", 32'(lsu_stall_o), 32'd0);
        check("rst.state", 32'(dbg_state_o), 32'd0);

        // Region boundaries, observed combinationally while idle.
        lsu_addr_i = 32'h10008000; #1; check("rgn.static_base", 32'(dbg_in_region_o), 32'd1);
        lsu_addr_i = 32'h10007FFF; #1; check("rgn.below",       32'(dbg_in_region_o), 32'd0);
        lsu_addr_i = 32'h100083FF; #1; check("rgn.heap_last",   32'(dbg_in_region_o), 32'd1);
        lsu_addr_i = 32'h10008400; #1; check("rgn.above_heap",  32'(dbg_in_region_o), 32'd0);
        lsu_addr_i = 32'hBFFFFFF0; #1; check("rgn.stack_last",  32'(dbg_in_region_o), 32'd1);
        lsu_addr_i = 32'hBFFFFFF1; #1; check("rgn.above_stack", 32'(dbg_in_region_o), 32'd0);
        tick();

        run_op("lw",  1'b0, 3'd2, 32'h10008004, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        run_op("lb",  1'b0, 3'd0, 32'h10008005, 32'h0, 32'h00008080, 32'hFFFFFF80);
        run_op("lbu", 1'b0, 3'd4, 32'h10008005, 32'h0, 32'h00008080, 32'h00000080);
        run_op("lh",  1'b0, 3'd1, 32'h10008006, 32'h0, 32'h00008080, 32'hFFFF8080);
        run_op("lhu", 1'b0, 3'd5, 32'h10008006, 32'h0, 32'h00008080, 32'h00008080);
        run_op("sw",  1'b1, 3'd2, 32'hBFFFFFF0, 32'h12345678, 32'hFFFFFFFF, 32'h00008080);
        run_op("lh_pos", 1'b0, 3'd1, 32'h10008200, 32'h0, 32'hABCD7FFF, 32'h00007FFF);
        run_op("lb_pos", 1'b0, 3'd0, 32'h10008201, 32'h0, 32'h1234567F, 32'h0000007F);

`ifdef LSU_FAULT_EN
        fault_op("f_lw_mis", 1'b0, 3'd2, 32'h10008002);
        fault_op("f_sb_out", 1'b1, 3'd0, 32'h20000000);
        fault_op("f_lh_mis", 1'b0, 3'd1, 32'h10008001);
        fault_op("f_size3",  1'b0, 3'd3, 32'h10008000);
        check("f.rdata_held", lsu_rdata_o, 32'h0000007F);
`else
        run_op("nf_lw_mis", 1'b0, 3'd2, 32'h10008002, 32'h0, 32'h0BADF00D, 32'h0BADF00D);
        run_op("nf_sb_out", 1'b1, 3'd0, 32'h20000000, 32'h000000A5, 32'h55555555, 32'h0BADF00D);
        check("nf.fault_tied", 32'(lsu_fault_o), 32'd0);
        check("nf.faddr_tied", lsu_fault_addr_o, 32'h0);
`endif

        // Request held high across two operations.
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_size_i  = 3'd2;
        lsu_addr_i  = 32'h10008010;
        lsu_wdata_i = 32'h0;
        tick();
        check("b2b.c1_req", 32'(mif.mem_req), 32'd1);
        mif.mem_rd = 32'h11112222;
        tick();
        tick();
        check("b2b.c3_done",  32'(lsu_done_o), 32'd1);
        check("b2b.c3_rdata", lsu_rdata_o, 32'h11112222);
        lsu_addr_i = 32'h10008020;
        tick();
        check("b2b.c4_req",   32'(mif.mem_req), 32'd0);
        check("b2b.c4_done",  32'(lsu_done_o), 32'd0);
        check("b2b.c4_state", 32'(dbg_state_o), 32'd0);
        check("b2b.c4_stall", 32'(lsu_stall_o), 32'd1);
        tick();
        check("b2b.c5_req",  32'(mif.mem_req), 32'd1);
        check("b2b.c5_addr", mif.mem_a, 32'h10008020);
        mif.mem_rd = 32'h33334444;
        tick();
        check("b2b.c6_req", 32'(mif.mem_req), 32'd0);
        tick();
        check("b2b.c7_done",  32'(lsu_done_o), 32'd1);
        check("b2b.c7_rdata", lsu_rdata_o, 32'h33334444);
        lsu_req_i = 1'b0;
        tick();
        check("b2b.c8_done", 32'(lsu_done_o), 32'd0);
        check("b2b.c8_req",  32'(mif.mem_req), 32'd0);

        // Reset while in REQ: nothing completes, then a fresh request works.
        lsu_req_i  = 1'b1;
        lsu_addr_i = 32'h10008030;
        tick();
        check("rstop.c1_req", 32'(mif.mem_req), 32'd1);
        reset     = 1'b1;
        lsu_req_i = 1'b0;
        tick();
        reset = 1'b0;
        check("rstop.req",   32'(mif.mem_req), 32'd0);
        check("rstop.done",  32'(lsu_done_o), 32'd0);
        check("rstop.state", 32'(dbg_state_o), 32'd0);
        check("rstop.rdata", lsu_rdata_o, 32'h0);
        tick();
        check("rstop.done2", 32'(lsu_done_o), 32'd0);
        run_op("after_rst", 1'b0, 3'd4, 32'h10008031, 32'h0, 32'h0000C3F0, 32'h000000F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
